// File: rtl/sd_cmd_issuer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sd_cmd_issuer_if                                             |
// | Description : CPU-side register bus between the SD command issuer and the  |
// |               SD host register file.                                       |
// |   req    initiator -> responder  bus request                               |
// |   rw     initiator -> responder  1 = read, 0 = write                       |
// |   addr   initiator -> responder  register word address                     |
// |   wdata  initiator -> responder  write data                                |
// |   rdata  responder -> initiator  read data, valid while ack is high        |
// |   ack    responder -> initiator  acknowledge                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface sd_cmd_issuer_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   logic              req;
   logic              rw;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ack;

   modport master (output req, rw, addr, wdata, input rdata, ack);
   modport slave  (input req, rw, addr, wdata, output rdata, ack);
endinterface
`default_nettype wire

// File: rtl/sd_cmd_issuer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sd_cmd_issuer                                                |
// | Description : Issues one SD command through the host register file:       |
// |               Argument write, Transfer_Mode/Command write, status polling, |
// |               Response0/1 read and status clear.                           |
// | Ports       : clk, rst_n        clock / async active-low reset             |
// |               i_start           begin a command (sampled in IDLE)          |
// |               i_cmd_index/flags/transfer_mode/argument  command fields     |
// |               o_busy, o_done    activity flag, one-cycle completion pulse  |
// |               o_cmd_err, o_timeout_err, o_response  results with o_done    |
// |               bus               register bus initiator (master modport)    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sd_cmd_issuer #(
   parameter int ADDR_W    = 5,
   parameter int DATA_W    = 32,
   parameter int MAX_POLLS = 1024
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   input  wire logic        i_start,
   input  wire logic [5:0]  i_cmd_index,
   input  wire logic [7:0]  i_cmd_flags,
   input  wire logic [15:0] i_transfer_mode,
   input  wire logic [31:0] i_argument,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_cmd_err,
   output logic             o_timeout_err,
   output logic [31:0]      o_response,
   sd_cmd_issuer_if.master  bus
);

   localparam logic [ADDR_W-1:0] c_ADDR_ARG  = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] c_ADDR_CMD  = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] c_ADDR_RESP = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] c_ADDR_STAT = ADDR_W'(12);
   localparam logic [15:0]       c_POLL_LAST = 16'(MAX_POLLS - 1);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ARG  = 3'd1,
      ST_CMD  = 3'd2,
      ST_POLL = 3'd3,
      ST_RESP = 3'd4,
      ST_CLR  = 3'd5,
      ST_DONE = 3'd6
   } state_t;

   state_t            r_state, w_state;
   logic              r_gap, w_gap;          // 0 = REQ phase, 1 = GAP phase
   logic              r_req, w_req;
   logic              r_rw, w_rw;
   logic [ADDR_W-1:0] r_addr, w_addr;
   logic [DATA_W-1:0] r_wdata, w_wdata;
   logic              r_busy, w_busy;
   logic              r_done, w_done;
   logic              r_cmd_err, w_cmd_err;
   logic              r_timeout_err, w_timeout_err;
   logic [31:0]       r_response, w_response;
   logic              r_stat_err, w_stat_err; // status bit15 of the last poll
   logic              r_stat_cc, w_stat_cc;   // status bit0 of the last poll
   logic [15:0]       r_poll_cnt, w_poll_cnt;
   logic [31:0]       r_cmd_word, w_cmd_word;

   // Access sequencing helpers
   logic              w_acc_end;              // GAP phase finished this edge
   logic              w_launch;
   logic              w_l_rw;
   logic [ADDR_W-1:0] w_l_addr;
   logic [DATA_W-1:0] w_l_wdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_gap         <= 1'b0;
         r_req         <= 1'b0;
         r_rw          <= 1'b1;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_cmd_err     <= 1'b0;
         r_timeout_err <= 1'b0;
         r_response    <= '0;
         r_stat_err    <= 1'b0;
         r_stat_cc     <= 1'b0;
         r_poll_cnt    <= '0;
         r_cmd_word    <= '0;
      end else begin
         r_state       <= w_state;
         r_gap         <= w_gap;
         r_req         <= w_req;
         r_rw          <= w_rw;
         r_addr        <= w_addr;
         r_wdata       <= w_wdata;
         r_busy        <= w_busy;
         r_done        <= w_done;
         r_cmd_err     <= w_cmd_err;
         r_timeout_err <= w_timeout_err;
         r_response    <= w_response;
         r_stat_err    <= w_stat_err;
         r_stat_cc     <= w_stat_cc;
         r_poll_cnt    <= w_poll_cnt;
         r_cmd_word    <= w_cmd_word;
      end
   end

   always_comb begin
      w_state       = r_state;
      w_gap         = r_gap;
      w_req         = r_req;
      w_rw          = r_rw;
      w_addr        = r_addr;
      w_wdata       = r_wdata;
      w_busy        = r_busy;
      w_done        = 1'b0;
      w_cmd_err     = r_cmd_err;
      w_timeout_err = r_timeout_err;
      w_response    = r_response;
      w_stat_err    = r_stat_err;
      w_stat_cc     = r_stat_cc;
      w_poll_cnt    = r_poll_cnt;
      w_cmd_word    = r_cmd_word;
      w_acc_end     = 1'b0;
      w_launch      = 1'b0;
      w_l_rw        = 1'b1;
      w_l_addr      = '0;
      w_l_wdata     = '0;

      // REQ/GAP handshake shared by every bus-access state. Read data is
      // captured on the edge ack is first seen; repeats while ack stays high
      // are harmless because the GAP phase ignores rdata.
      if (r_state != ST_IDLE && r_state != ST_DONE) begin
         if (!r_gap) begin
            if (bus.ack) begin
               w_req = 1'b0;
               w_gap = 1'b1;
               if (r_state == ST_POLL) begin
                  w_stat_err = bus.rdata[15];
                  w_stat_cc  = bus.rdata[0];
               end
               if (r_state == ST_RESP) begin
                  w_response = bus.rdata[31:0];
               end
            end
         end else if (!bus.ack) begin
            w_gap     = 1'b0;
            w_acc_end = 1'b1;
         end
      end

      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_busy        = 1'b1;
               w_cmd_err     = 1'b0;
               w_timeout_err = 1'b0;
               w_poll_cnt    = '0;
               w_cmd_word    = {2'b00, i_cmd_index, i_cmd_flags, i_transfer_mode};
               w_state       = ST_ARG;
               w_launch      = 1'b1;
               w_l_rw        = 1'b0;
               w_l_addr      = c_ADDR_ARG;
               w_l_wdata     = DATA_W'(i_argument);
            end
         end
         ST_ARG: begin
            if (w_acc_end) begin
               w_state   = ST_CMD;
               w_launch  = 1'b1;
               w_l_rw    = 1'b0;
               w_l_addr  = c_ADDR_CMD;
               w_l_wdata = DATA_W'(r_cmd_word);
            end
         end
         ST_CMD: begin
            if (w_acc_end) begin
               w_state  = ST_POLL;
               w_launch = 1'b1;
               w_l_addr = c_ADDR_STAT;
            end
         end
         ST_POLL: begin
            // Decision uses the status word captured during the access just ended.
            if (w_acc_end) begin
               if (r_stat_err) begin
                  w_cmd_err = 1'b1;
                  w_state   = ST_CLR;
                  w_launch  = 1'b1;
                  w_l_rw    = 1'b0;
                  w_l_addr  = c_ADDR_STAT;
               end else if (r_stat_cc) begin
                  w_state  = ST_RESP;
                  w_launch = 1'b1;
                  w_l_addr = c_ADDR_RESP;
               end else if (r_poll_cnt == c_POLL_LAST) begin
                  // Timeout leaves the status register untouched.
                  w_timeout_err = 1'b1;
                  w_state       = ST_DONE;
                  w_done        = 1'b1;
                  w_busy        = 1'b0;
               end else begin
                  w_poll_cnt = r_poll_cnt + 16'd1;
                  w_launch   = 1'b1;
                  w_l_addr   = c_ADDR_STAT;
               end
            end
         end
         ST_RESP: begin
            if (w_acc_end) begin
               w_state  = ST_CLR;
               w_launch = 1'b1;
               w_l_rw   = 1'b0;
               w_l_addr = c_ADDR_STAT;
            end
         end
         ST_CLR: begin
            if (w_acc_end) begin
               w_state = ST_DONE;
               w_done  = 1'b1;
               w_busy  = 1'b0;
            end
         end
         ST_DONE: begin
            w_state = ST_IDLE;
         end
         default: begin
            w_state = ST_IDLE;
         end
      endcase

      if (w_launch) begin
         w_req   = 1'b1;
         w_rw    = w_l_rw;
         w_addr  = w_l_addr;
         w_wdata = w_l_wdata;
      end
   end

   assign bus.req       = r_req;
   assign bus.rw        = r_rw;
   assign bus.addr      = r_addr;
   assign bus.wdata     = r_wdata;
   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_cmd_err     = r_cmd_err;
   assign o_timeout_err = r_timeout_err;
   assign o_response    = r_response;

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_issuer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sd_cmd_issuer                                             |
// | Description : Directed self-checking bench for sd_cmd_issuer with a        |
// |               register-file responder of configurable ack delay/hold.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_sd_cmd_issuer;

   localparam int ADDR_W    = 5;
   localparam int DATA_W    = 32;
   localparam int MAX_POLLS = 4;
   localparam int LOG_SZ    = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [5:0]  cmd_index = '0;
   logic [7:0]  cmd_flags = '0;
   logic [15:0] transfer_mode = '0;
   logic [31:0] argument = '0;
   logic        busy, done, cmd_err, timeout_err;
   logic [31:0] response;

   always #5 clk = ~clk;

   sd_cmd_issuer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   sd_cmd_issuer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_POLLS(MAX_POLLS)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_start         (start),
      .i_cmd_index     (cmd_index),
      .i_cmd_flags     (cmd_flags),
      .i_transfer_mode (transfer_mode),
      .i_argument      (argument),
      .o_busy          (busy),
      .o_done          (done),
      .o_cmd_err       (cmd_err),
      .o_timeout_err   (timeout_err),
      .o_response      (response),
      .bus             (bus.master)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- responder and access log ----------------
   int          ack_delay = 0;
   int          ack_hold  = 0;
   int          dly_cnt = 0;
   int          hold_cnt = 0;
   int          acc_n = 0;
   logic        acc_rw   [LOG_SZ];
   logic [4:0]  acc_addr [LOG_SZ];
   logic [31:0] acc_data [LOG_SZ];
   int          n12 = 0;
   int          n12_base = 0;
   logic [31:0] stat_seq [4];
   int          stat_len = 1;
   logic [31:0] resp_word = '0;

   always @(posedge clk) begin
      if (!rst_n) begin
         bus.ack   <= 1'b0;
         bus.rdata <= '0;
         dly_cnt   <= 0;
         hold_cnt  <= 0;
      end else if (!bus.ack) begin
         hold_cnt <= 0;
         if (bus.req) begin
            if (dly_cnt >= ack_delay) begin
               bus.ack <= 1'b1;
               dly_cnt <= 0;
               if (acc_n < LOG_SZ) begin
                  acc_rw[acc_n]   <= bus.rw;
                  acc_addr[acc_n] <= bus.addr;
                  acc_data[acc_n] <= bus.wdata;
               end
               acc_n <= acc_n + 1;
               if (bus.rw && bus.addr == 5'd12) begin
                  bus.rdata <= stat_seq[(n12 - n12_base < stat_len) ? (n12 - n12_base) : (stat_len - 1)];
                  n12 <= n12 + 1;
               end else if (bus.rw && bus.addr == 5'd4) begin
                  bus.rdata <= resp_word;
               end else begin
                  bus.rdata <= '0;
               end
            end else begin
               dly_cnt <= dly_cnt + 1;
            end
         end else begin
            dly_cnt <= 0;
         end
      end else if (!bus.req) begin
         if (hold_cnt >= ack_hold) bus.ack <= 1'b0;
         else hold_cnt <= hold_cnt + 1;
      end
   end

   // Protocol monitor: req may only fall after ack, and may not rise while ack is high.
   logic prev_req = 1'b0;
   int   viol = 0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.req && !prev_req && bus.ack) viol <= viol + 1;
         if (!bus.req && prev_req && !bus.ack) viol <= viol + 1;
      end
      prev_req <= bus.req;
   end

   // ---------------- checking ----------------
   int n_chk  = 0;
   int n_pass = 0;
   int t_start = 0;
   int base = 0;
   int lat;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   function automatic int count_acc(input int from, input logic rw, input logic [4:0] a);
      int n = 0;
      for (int i = from; i < acc_n && i < LOG_SZ; i++)
         if (acc_rw[i] == rw && acc_addr[i] == a) n++;
      return n;
   endfunction

   task automatic chk_acc(input string tag, input int idx, input logic rw,
                          input logic [4:0] a, input logic [31:0] d);
      chk({tag, "_rw"}, 32'(acc_rw[idx]), 32'(rw));
      chk({tag, "_addr"}, 32'(acc_addr[idx]), 32'(a));
      if (!rw) chk({tag, "_data"}, acc_data[idx], d);
   endtask

   task automatic start_cmd(input logic [31:0] arg, input logic [5:0] idx,
                            input logic [7:0] fl, input logic [15:0] tm);
      @(negedge clk);
      argument = arg; cmd_index = idx; cmd_flags = fl; transfer_mode = tm;
      start = 1'b1;
      @(posedge clk); #1;
      t_start  = cyc;
      start    = 1'b0;
      base     = acc_n;
      n12_base = n12;
   endtask

   task automatic wait_done(output int l);
      l = -1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (done) begin
            l = cyc - t_start;
            break;
         end
      end
      if (l < 0) chk("done_seen", 32'd0, 32'd1);
   endtask

   initial begin
      stat_seq[0] = 32'h1; stat_seq[1] = 32'h1; stat_seq[2] = 32'h1; stat_seq[3] = 32'h1;

      // ---- reset state ----
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req", 32'(bus.req), 32'd0);
      chk("rst_rw", 32'(bus.rw), 32'd1);
      chk("rst_addr", 32'(bus.addr), 32'd0);
      chk("rst_wdata", bus.wdata, 32'd0);
      chk("rst_flags", {28'd0, busy, done, cmd_err, timeout_err}, 32'd0);
      chk("rst_resp", response, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // ---- scenario 1: nominal command ----
      stat_seq[0] = 32'h1; stat_len = 1; resp_word = 32'hDEADBEEF;
      start_cmd(32'h12345678, 6'd17, 8'h1A, 16'h0013);
      chk("s1_busy", 32'(busy), 32'd1);
      wait_done(lat);
      chk("s1_lat", lat, 32'd20);
      chk("s1_resp", response, 32'hDEADBEEF);
      chk("s1_errs", {30'd0, cmd_err, timeout_err}, 32'd0);
      chk("s1_busy_done", 32'(busy), 32'd0);
      chk("s1_nacc", acc_n - base, 32'd5);
      chk_acc("s1_a0", base + 0, 1'b0, 5'd2, 32'h12345678);
      chk_acc("s1_a1", base + 1, 1'b0, 5'd3, 32'h111A0013);
      chk_acc("s1_a2", base + 2, 1'b1, 5'd12, 32'h0);
      chk_acc("s1_a3", base + 3, 1'b1, 5'd4, 32'h0);
      chk_acc("s1_a4", base + 4, 1'b0, 5'd12, 32'h0);
      @(negedge clk);
      chk("s1_done_pulse", 32'(done), 32'd0);

      // ---- scenario 2: two not-ready polls ----
      stat_seq[0] = 32'h0; stat_seq[1] = 32'h0; stat_seq[2] = 32'h1; stat_len = 3;
      start_cmd(32'h00000001, 6'd8, 8'h1A, 16'h0000);
      wait_done(lat);
      chk("s2_lat", lat, 32'd28);
      chk("s2_polls", count_acc(base, 1'b1, 5'd12), 32'd3);
      chk("s2_resp", response, 32'hDEADBEEF);

      // ---- scenario 3: error bit wins over complete ----
      stat_seq[0] = 32'h00008001; stat_len = 1; resp_word = 32'h55555555;
      start_cmd(32'hA5A5A5A5, 6'd2, 8'h09, 16'h0000);
      wait_done(lat);
      chk("s3_lat", lat, 32'd16);
      chk("s3_cmd_err", 32'(cmd_err), 32'd1);
      chk("s3_tmo", 32'(timeout_err), 32'd0);
      chk("s3_no_resp_rd", count_acc(base, 1'b1, 5'd4), 32'd0);
      chk("s3_clr_wr", count_acc(base, 1'b0, 5'd12), 32'd1);
      chk("s3_resp_hold", response, 32'hDEADBEEF);

      // ---- scenario 4: timeout after MAX_POLLS reads ----
      stat_seq[0] = 32'h0; stat_len = 1;
      start_cmd(32'h0, 6'd13, 8'h1A, 16'h0000);
      chk("s4_err_cleared", 32'(cmd_err), 32'd0);
      wait_done(lat);
      chk("s4_lat", lat, 32'd24);
      chk("s4_polls", count_acc(base, 1'b1, 5'd12), 32'd4);
      chk("s4_tmo", 32'(timeout_err), 32'd1);
      chk("s4_cmd_err", 32'(cmd_err), 32'd0);
      chk("s4_no_clr", count_acc(base, 1'b0, 5'd12), 32'd0);

      // ---- scenario 5: slow responder, input changes and start while busy ----
      ack_delay = 3; ack_hold = 2;
      stat_seq[0] = 32'h1; stat_len = 1; resp_word = 32'hDEADBEEF;
      start_cmd(32'h12345678, 6'd17, 8'h1A, 16'h0013);
      argument = 32'hFFFFFFFF; cmd_index = 6'h3F; cmd_flags = 8'hFF; transfer_mode = 16'hFFFF;
      repeat (6) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat);
      chk("s5_tmo", 32'(timeout_err), 32'd0);
      chk("s5_resp", response, 32'hDEADBEEF);
      chk("s5_nacc", acc_n - base, 32'd5);
      chk_acc("s5_a0", base + 0, 1'b0, 5'd2, 32'h12345678);
      chk_acc("s5_a1", base + 1, 1'b0, 5'd3, 32'h111A0013);
      chk_acc("s5_a2", base + 2, 1'b1, 5'd12, 32'h0);
      chk_acc("s5_a3", base + 3, 1'b1, 5'd4, 32'h0);
      chk_acc("s5_a4", base + 4, 1'b0, 5'd12, 32'h0);
      chk("s5_proto", viol, 32'd0);
      repeat (5) @(negedge clk);
      ack_delay = 0; ack_hold = 0;

      // ---- scenario 6: reset during POLL, then a full clean command ----
      stat_seq[0] = 32'h0; stat_len = 1; resp_word = 32'hCAFEF00D;
      start_cmd(32'h0BADF00D, 6'd55, 8'h1A, 16'h0000);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (count_acc(base, 1'b1, 5'd12) >= 1) break;
      end
      chk("s6_in_poll", (count_acc(base, 1'b1, 5'd12) >= 1) ? 32'd1 : 32'd0, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("s6_req_async", 32'(bus.req), 32'd0);
      chk("s6_busy_async", 32'(busy), 32'd0);
      chk("s6_resp_rst", response, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      base = acc_n;
      repeat (6) @(negedge clk);
      chk("s6_quiet", acc_n - base, 32'd0);
      stat_seq[0] = 32'h1;
      start_cmd(32'h12345678, 6'd17, 8'h1A, 16'h0013);
      wait_done(lat);
      chk("s6_lat", lat, 32'd20);
      chk("s6_nacc", acc_n - base, 32'd5);
      chk_acc("s6_a0", base + 0, 1'b0, 5'd2, 32'h12345678);
      chk("s6_resp", response, 32'hCAFEF00D);
      chk("s6_proto", viol, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sd_cmd_issuer.md
Name: sd_cmd_issuer

Overview:
- Register-bus initiator that drives the SD host register file's CPU-side port (req/rw/addr/wdata/rdata/ack) to issue one SD command end to end.
- Sequence: write Argument (word 2), write Transfer_Mode/Command (word 3), poll Normal/Error Interrupt Status (word 12), read Response0/1 (word 4), clear status.
- Sits between the controller's command-scheduling logic and the register file.

Parameters:
- ADDR_W, 5, register word address width
- DATA_W, 32, register data width
- MAX_POLLS, 1024, status reads before timeout_err; legal range 2..65535

Ports:
- clk  in  1  clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a command; sampled only in IDLE
- cmd_index  in  6  CMD number, goes to Command[13:8]
- cmd_flags  in  8  response type/CRC/index check bits, goes to Command[7:0]
- transfer_mode  in  16  Transfer_Mode value
- argument  in  32  command argument
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse
- cmd_err  out  1  status read showed the error bit; valid with done
- timeout_err  out  1  MAX_POLLS status reads without completion; valid with done
- response  out  32  word 4 contents; valid with done when no error
- req  out  1  bus request
- rw  out  1  1 = read, 0 = write
- addr  out  ADDR_W  register word address
- wdata  out  DATA_W  write data
- rdata  in  DATA_W  read data, valid in the cycle ack is high
- ack  in  1  responder acknowledge

Behaviour:
- Reset values: req=0, rw=1, addr=0, wdata=0, busy=0, done=0, cmd_err=0, timeout_err=0, response=0, poll counter=0, state=IDLE.
- Reset asserted mid-operation aborts at once: req drops asynchronously, and no further bus access is issued.
- Bus protocol, per access:
  - REQ phase: req=1 with rw/addr/wdata held stable until ack is sampled 1. For reads, rdata is captured on that edge.
  - GAP phase: req=0 until ack is sampled 0. The next access may then start on that same edge.
  - With a responder that registers ack one cycle after req, each access is exactly 4 cycles.
  - A responder that re-executes an access while req is still high is tolerated: every write is idempotent and reads are side-effect free.
- States:
  - IDLE: busy=0. On start=1, load outputs for the first access and go to ARG.
  - ARG: write addr 2, wdata=argument.
  - CMD: write addr 3, wdata={2'b00, cmd_index, cmd_flags, transfer_mode}; Command is in [31:16] and Transfer_Mode in [15:0].
  - POLL: read addr 12; decide on the captured word after its GAP.
    - bit15 (Error Interrupt) = 1: set cmd_err and go to CLR. Error takes priority over bit0.
    - else bit0 (Command Complete) = 1: go to RESP.
    - else if poll count = MAX_POLLS-1: set timeout_err and go to DONE, skipping the clear.
    - else increment the poll count and repeat POLL.
  - RESP: read addr 4 into response, then go to CLR.
  - CLR: write addr 12, wdata=0, then go to DONE.
  - DONE: done=1 for one cycle, busy=0, return to IDLE. cmd_err, timeout_err and response hold until the next start is accepted, which clears the two error flags and the poll count.
- start while busy is ignored. start held high across done begins a new command in the cycle after done.
- Inputs cmd_index, cmd_flags, transfer_mode and argument are sampled at start acceptance and registered; later changes have no effect on the command in flight.
- The ack wait is unbounded; there is no bus watchdog in this block.

Test Plan:
- Compliant 1-cycle-ack responder, first status read = 0x00000001, arg=0x12345678, cmd_index=17, cmd_flags=0x1A, transfer_mode=0x0013, word 4 = 0xDEADBEEF:
  - write word 2 = 0x12345678;
  - write word 3 = 0x111A0013;
  - one read of word 12;
  - read of word 4;
  - write word 12 = 0;
  - done exactly 20 cycles after the start-sample edge, response=0xDEADBEEF, both error flags 0.
- Status reads 0, 0, then 0x00000001: exactly 3 reads of word 12, and done 28 cycles after start.
- Status 0x00008001: cmd_err=1, no read of word 4, clear write issued, response unchanged from its previous value.
- MAX_POLLS=4, status always 0: exactly 4 reads of word 12, timeout_err=1, no clear write, done 24 cycles after start.
- Responder adds 3-cycle ack delay and holds ack high 2 extra cycles: req stays high until ack is seen, no new req while ack is high, and all addresses and data match the first scenario.
- rst_n pulsed low during POLL: req=0 and busy=0 immediately; start=1 after release runs a full sequence starting from the word 2 write.
